sprite_motion_controller: RTL and testbench

//  Upstream stage of the sprite renderer: owns the sprite position and visibility.

---
 rtl/sprite_motion_controller.sv | 160 ++++++++++++++++
 tb/tb_sprite_motion_controller.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/sprite_motion_controller.sv
// Sprite motion controller: upstream stage of the sprite renderer.
// Synchronises the direction/centre buttons, detects the frame boundary from
// the VGA counters and moves the sprite once per frame with clamping and a
// two-speed (slow, then fast after a sustained hold) acceleration.
// Ports:
//   Clock, Reset               pixel clock, synchronous active-high reset
//   iColumnCount, iRowCount    VGA scan position
//   iUp/iDown/iLeft/iRight     asynchronous direction buttons, active-high
//   iCenter                    asynchronous recentre button, active-high
//   oPosX, oPosY               sprite top-left corner (registered)
//   oEnable                    sprite visible (registered)
//   oFrameTick                 one-cycle pulse at each frame boundary
module sprite_motion_controller #(
  parameter int unsigned SizeX      = 32,
  parameter int unsigned SizeY      = 32,
  parameter int unsigned ScreenW    = 640,
  parameter int unsigned ScreenH    = 480,
  parameter int unsigned StepSlow   = 1,
  parameter int unsigned StepFast   = 4,
  parameter int unsigned HoldFrames = 8,
  parameter int unsigned InitX      = 304,
  parameter int unsigned InitY      = 224
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [9:0] iColumnCount,
  input  logic [9:0] iRowCount,
  input  logic       iUp,
  input  logic       iDown,
  input  logic       iLeft,
  input  logic       iRight,
  input  logic       iCenter,
  output logic [9:0] oPosX,
  output logic [9:0] oPosY,
  output logic       oEnable,
  output logic       oFrameTick
);

  localparam int unsigned PosW = 10;
  localparam int unsigned SumW = 11;
  localparam int unsigned CntW = $clog2(HoldFrames + 1);
  localparam int unsigned MaxX = ScreenW - 1 - SizeX;
  localparam int unsigned MaxY = ScreenH - 1 - SizeY;

  typedef enum logic [1:0] {INIT, IDLE, SLOW, FAST} state_t;

  state_t          state, state_nxt;
  logic [CntW-1:0] cnt, cnt_nxt;
  logic [PosW-1:0] pos_x_nxt, pos_y_nxt;
  logic            enable_nxt;

  // Button order: {centre, up, down, left, right}
  logic [4:0] btn_meta, btn_sync;
  logic       match_r, match_d;

  logic btn_c, btn_u, btn_d, btn_l, btn_r, any_dir;
  assign {btn_c, btn_u, btn_d, btn_l, btn_r} = btn_sync;
  // Left+Right together still counts as held even though it cancels out.
  assign any_dir = btn_u | btn_d | btn_l | btn_r;

  // One axis step in 11-bit signed arithmetic, clamped to [0, lim].
  function automatic logic [PosW-1:0] move_axis(input logic [PosW-1:0] pos,
                                                input logic inc, input logic dec,
                                                input logic [SumW-1:0] step,
                                                input logic [SumW-1:0] lim);
    logic signed [SumW-1:0] sum;
    sum = $signed({1'b0, pos});
    if (inc && !dec)      sum = sum + $signed(step);
    else if (dec && !inc) sum = sum - $signed(step);
    if (sum < 0)                 return '0;
    else if (sum > $signed(lim)) return lim[PosW-1:0];
    else                         return sum[PosW-1:0];
  endfunction

  // Synchroniser and frame-boundary edge detector.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      btn_meta   <= '0;
      btn_sync   <= '0;
      match_r    <= 1'b0;
      match_d    <= 1'b0;
      oFrameTick <= 1'b0;
    end else begin
      btn_meta   <= {iCenter, iUp, iDown, iLeft, iRight};
      btn_sync   <= btn_meta;
      match_r    <= (iColumnCount == PosW'(ScreenW)) && (iRowCount == PosW'(ScreenH));
      match_d    <= match_r;
      oFrameTick <= match_r & ~match_d;
    end
  end

  // State and position registers; only advance on a frame tick.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state   <= INIT;
      cnt     <= '0;
      oPosX   <= PosW'(InitX);
      oPosY   <= PosW'(InitY);
      oEnable <= 1'b0;
    end else if (oFrameTick) begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      oPosX   <= pos_x_nxt;
      oPosY   <= pos_y_nxt;
      oEnable <= enable_nxt;
    end
  end

  // Next-state, movement and counter logic.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    pos_x_nxt  = oPosX;
    pos_y_nxt  = oPosY;
    enable_nxt = oEnable;
    case (state)
      INIT: begin
        state_nxt  = IDLE;
        enable_nxt = 1'b1;
      end
      IDLE: begin
        if (any_dir) begin
          state_nxt = SLOW;
          cnt_nxt   = CntW'(1);
          pos_x_nxt = move_axis(oPosX, btn_r, btn_l, SumW'(StepSlow), SumW'(MaxX));
          pos_y_nxt = move_axis(oPosY, btn_d, btn_u, SumW'(StepSlow), SumW'(MaxY));
        end
      end
      SLOW: begin
        if (!any_dir) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt   = cnt + CntW'(1);
          pos_x_nxt = move_axis(oPosX, btn_r, btn_l, SumW'(StepSlow), SumW'(MaxX));
          pos_y_nxt = move_axis(oPosY, btn_d, btn_u, SumW'(StepSlow), SumW'(MaxY));
          if (cnt == CntW'(HoldFrames - 1)) state_nxt = FAST;
        end
      end
      FAST: begin
        if (!any_dir) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          pos_x_nxt = move_axis(oPosX, btn_r, btn_l, SumW'(StepFast), SumW'(MaxX));
          pos_y_nxt = move_axis(oPosY, btn_d, btn_u, SumW'(StepFast), SumW'(MaxY));
        end
      end
      default: state_nxt = INIT;
    endcase
    // Centre wins over any direction once the sprite is live.
    if (btn_c && state != INIT) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      pos_x_nxt = PosW'(InitX);
      pos_y_nxt = PosW'(InitY);
    end
  end

endmodule

// File: tb/tb_sprite_motion_controller.sv
// Directed bench for sprite_motion_controller: drives short synthetic frames
// (counters parked at 640/480 for a few cycles) and checks position, visibility,
// controller state and frame tick against hand-computed values.
module tb_sprite_motion_controller;

  logic       Clock = 1'b0;
  logic       Reset;
  logic [9:0] iColumnCount, iRowCount;
  logic       iUp, iDown, iLeft, iRight, iCenter;
  logic [9:0] oPosX, oPosY;
  logic       oEnable, oFrameTick;

  localparam logic [31:0] ST_INIT = 0, ST_IDLE = 1, ST_SLOW = 2, ST_FAST = 3;

  int checks = 0;
  int errors = 0;
  int tick_seen;

  sprite_motion_controller dut (
    .Clock(Clock), .Reset(Reset),
    .iColumnCount(iColumnCount), .iRowCount(iRowCount),
    .iUp(iUp), .iDown(iDown), .iLeft(iLeft), .iRight(iRight), .iCenter(iCenter),
    .oPosX(oPosX), .oPosY(oPosY), .oEnable(oEnable), .oFrameTick(oFrameTick)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One frame boundary with the match held for 'hold' cycles; counts ticks seen.
  task automatic do_frame(input int hold);
    tick_seen = 0;
    iColumnCount = 10'd640;
    iRowCount    = 10'd480;
    repeat (hold) begin
      @(posedge Clock); #1;
      tick_seen += int'(oFrameTick);
    end
    iColumnCount = 10'd0;
    iRowCount    = 10'd0;
    repeat (5) begin
      @(posedge Clock); #1;
      tick_seen += int'(oFrameTick);
    end
  endtask

  task automatic frames(input int n);
    repeat (n) do_frame(1);
  endtask

  task automatic set_btn(input logic c, input logic u, input logic d,
                         input logic l, input logic r);
    iCenter = c; iUp = u; iDown = d; iLeft = l; iRight = r;
    repeat (3) @(posedge Clock);
    #1;
  endtask

  task automatic check_pos(input string tag, input int x, input int y);
    check({tag, "_x"}, 32'(oPosX), 32'(x));
    check({tag, "_y"}, 32'(oPosY), 32'(y));
  endtask

  initial begin
    Reset = 1'b1;
    iColumnCount = '0; iRowCount = '0;
    iUp = 0; iDown = 0; iLeft = 0; iRight = 0; iCenter = 0;
    repeat (3) @(posedge Clock);
    #1;
    check_pos("reset", 304, 224);
    check("reset_en", 32'(oEnable), 0);
    check("reset_tick", 32'(oFrameTick), 0);
    Reset = 1'b0;
    repeat (3) @(posedge Clock);
    #1;
    check("pre_tick_en", 32'(oEnable), 0);
    check("reset_state", 32'(dut.state), ST_INIT);

    // Frame 1: INIT -> IDLE, sprite becomes visible without moving.
    do_frame(1);
    check("f1_en", 32'(oEnable), 1);
    check_pos("f1", 304, 224);
    check("f1_state", 32'(dut.state), ST_IDLE);
    // Frame 2 with the match held three cycles: exactly one tick.
    do_frame(3);
    check("held_match_ticks", 32'(tick_seen), 1);
    check_pos("f2", 304, 224);

    // Right held 12 frames: 8 slow (+1) then 4 fast (+4).
    set_btn(0, 0, 0, 0, 1);
    frames(1);
    check("r1_x", 32'(oPosX), 305);
    check("r1_state", 32'(dut.state), ST_SLOW);
    frames(7);
    check("r8_x", 32'(oPosX), 312);
    check("r8_state", 32'(dut.state), ST_FAST);
    frames(1);
    check("r9_x", 32'(oPosX), 316);
    frames(3);
    check_pos("r12", 328, 224);
    set_btn(0, 0, 0, 0, 0);
    frames(1);
    check("release_state", 32'(dut.state), ST_IDLE);
    check("release_x", 32'(oPosX), 328);

    // A one-cycle glitch between ticks must not move the sprite.
    iRight = 1'b1;
    @(posedge Clock); #1;
    iRight = 1'b0;
    repeat (4) @(posedge Clock);
    #1;
    frames(1);
    check("glitch_x", 32'(oPosX), 328);
    check("glitch_state", 32'(dut.state), ST_IDLE);

    // Walk left down to X=4, then approach the left edge slowly.
    set_btn(0, 0, 0, 1, 0);
    frames(8);
    check("l8_x", 32'(oPosX), 320);
    frames(79);
    check("l87_x", 32'(oPosX), 4);
    set_btn(0, 0, 0, 0, 0);
    frames(1);
    set_btn(0, 0, 0, 1, 0);
    frames(2);
    check("l_to2_x", 32'(oPosX), 2);
    set_btn(0, 0, 0, 0, 0);
    frames(1);
    set_btn(0, 0, 0, 1, 0);
    frames(1);
    check("l_edge1_x", 32'(oPosX), 1);
    frames(1);
    check("l_edge0_x", 32'(oPosX), 0);
    frames(1);
    check("l_clamp_x", 32'(oPosX), 0);
    check("l_clamp_state", 32'(dut.state), ST_SLOW);
    set_btn(0, 0, 0, 0, 0);
    frames(1);

    // Run right to the clamp at 607.
    set_btn(0, 0, 0, 0, 1);
    frames(8 + 149);
    check("rmax_604_x", 32'(oPosX), 604);
    frames(1);
    check("rmax_607_x", 32'(oPosX), 607);
    frames(1);
    check("rmax_hold_x", 32'(oPosX), 607);
    check("rmax_state", 32'(dut.state), ST_FAST);
    set_btn(0, 0, 0, 0, 0);
    frames(1);

    // Centre from IDLE.
    set_btn(1, 0, 0, 0, 0);
    frames(1);
    check_pos("centre1", 304, 224);
    set_btn(0, 0, 0, 0, 0);

    // Left+Right cancel in X, Up still moves Y.
    set_btn(0, 1, 0, 1, 1);
    frames(3);
    check_pos("lru", 304, 221);
    check("lru_state", 32'(dut.state), ST_SLOW);
    set_btn(1, 0, 0, 0, 0);
    frames(1);
    check_pos("centre2", 304, 224);
    set_btn(0, 0, 0, 0, 0);

    // Reach 400,300 in FAST, then centre with Down still held.
    set_btn(0, 0, 0, 0, 1);
    frames(30);
    check("to400_x", 32'(oPosX), 400);
    set_btn(0, 0, 0, 0, 0);
    frames(1);
    set_btn(0, 0, 1, 0, 0);
    frames(25);
    check_pos("fast_pt", 400, 300);
    check("fast_pt_state", 32'(dut.state), ST_FAST);
    set_btn(1, 0, 1, 0, 0);
    frames(1);
    check_pos("centre_dn", 304, 224);
    check("centre_dn_state", 32'(dut.state), ST_IDLE);
    set_btn(0, 0, 0, 0, 0);

    // Mid-frame reset hides the sprite until the next tick.
    set_btn(0, 0, 0, 0, 1);
    frames(1);
    check("pre_rst_x", 32'(oPosX), 305);
    set_btn(0, 0, 0, 0, 0);
    Reset = 1'b1;
    @(posedge Clock); #1;
    Reset = 1'b0;
    check("midrst_en", 32'(oEnable), 0);
    check_pos("midrst", 304, 224);
    check("midrst_state", 32'(dut.state), ST_INIT);
    repeat (3) @(posedge Clock);
    #1;
    frames(1);
    check("midrst_f1_en", 32'(oEnable), 1);
    check("midrst_f1_state", 32'(dut.state), ST_IDLE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
